instr_mem_param: RTL and testbench

//  Parametrised instruction memory for the datapath fetch stage. DEPTH words of DATA_WIDTH bits.

---
 rtl/instr_mem_param.sv | 112 +++++++++++
 tb/tb_instr_mem_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_param.sv
// Parametrised instruction memory for the fetch stage.
// After reset an init sequencer fills every word with a known pattern. Once the
// sequencer finishes, the block accepts synchronous fetches and run-time loads.
//
// Fetch handshake: fetch_req is sampled at a rising edge only while ready=1.
// The requested word appears on fetch_data after that same edge, and
// fetch_valid is high for exactly that one cycle. A request is accepted on
// every cycle it is presented, and nothing is queued while ready=0.
// Load: load_en writes at the sampling edge while ready=1. While ready=0 the
// write is dropped, and load_err is raised for the following cycle.
module instr_mem_param #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int INIT_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_err,
  output logic                  ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // One extra counter bit lets the terminal count DEPTH be seen without wrapping.
  localparam int CW    = ADDR_WIDTH + 1;
  // The number of address bits that fit into a data word.
  localparam int PW    = (DATA_WIDTH < ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // The init pattern is the address, zero-extended or truncated to the word width.
  // It is all zeros when INIT_MODE is 1.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    if (INIT_MODE == 0) begin
      for (int i = 0; i < PW; i++) p[i] = a[i];
    end
    return p;
  endfunction

  // Next state and write-port selection: the init sequencer owns the write port
  // during INIT, and the load port owns it afterwards.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_we     = 1'b0;
    mem_waddr  = load_addr;
    mem_wdata  = load_data;
    case (state)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt[ADDR_WIDTH-1:0];
        mem_wdata = pattern(cnt[ADDR_WIDTH-1:0]);
        cnt_next  = cnt + 1'b1;
        if (cnt_next == CW'(DEPTH)) state_next = ST_READY;
      end
      ST_READY: begin
        mem_we = load_en;
      end
    endcase
  end

  // State register and init counter. The FSM restarts at address 0 on any reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Memory array write port. It has no reset because the init sequencer rewrites every word.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered fetch response and load-error pulse. The read happens before any
  // same-edge write, so a fetch and a load to the same address return the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      load_err    <= 1'b0;
    end else begin
      fetch_valid <= (state == ST_READY) && fetch_req;
      load_err    <= (state == ST_INIT) && load_en;
      if ((state == ST_READY) && fetch_req) fetch_data <= mem[fetch_addr];
    end
  end

  assign ready = (state == ST_READY);

endmodule

// File: tb/tb_instr_mem_param.sv
// Bench for instr_mem_param: default 64x64 instance (a) and a 32-bit, 16-word instance (b).
module tb_instr_mem_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, req_a, ld_a, valid_a, err_a, ready_a;
  logic [5:0]  faddr_a, laddr_a;
  logic [63:0] ldata_a, data_a;

  logic        rst_b, req_b, ld_b, valid_b, err_b, ready_b;
  logic [3:0]  faddr_b, laddr_b;
  logic [31:0] ldata_b, data_b;

  instr_mem_param dut_a (
    .clk(clk), .reset(rst_a),
    .fetch_req(req_a), .fetch_addr(faddr_a), .fetch_valid(valid_a), .fetch_data(data_a),
    .load_en(ld_a), .load_addr(laddr_a), .load_data(ldata_a), .load_err(err_a),
    .ready(ready_a)
  );

  instr_mem_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .INIT_MODE(0)) dut_b (
    .clk(clk), .reset(rst_b),
    .fetch_req(req_b), .fetch_addr(faddr_b), .fetch_valid(valid_b), .fetch_data(data_b),
    .load_en(ld_b), .load_addr(laddr_b), .load_data(ldata_b), .load_err(err_b),
    .ready(ready_b)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        req;
    logic [5:0]  faddr;
    logic        ld;
    logic [5:0]  laddr;
    logic [63:0] ldata;
    logic        exp_valid;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic req, input logic [5:0] faddr, input logic ld,
                              input logic [5:0] laddr, input logic [63:0] ldata,
                              input logic exp_valid, input logic [63:0] exp_data);
    vec_t v;
    v.req = req; v.faddr = faddr; v.ld = ld; v.laddr = laddr; v.ldata = ldata;
    v.exp_valid = exp_valid; v.exp_data = exp_data;
    return v;
  endfunction

  // ---------------- driver tasks (instance a) ----------------
  task automatic idle_a();
    req_a = 1'b0; faddr_a = '0; ld_a = 1'b0; laddr_a = '0; ldata_a = '0;
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    idle_a();
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, ready_a}, 64'd0);
    check("rst_valid", {63'd0, valid_a}, 64'd0);
    check("rst_data", data_a, 64'd0);
    check("rst_err", {63'd0, err_a}, 64'd0);
    rst_a = 1'b0;
  endtask

  // Counts edges from the reset release until ready. Optionally hits the block with
  // a fetch and a load 10 cycles in, and checks that both are rejected.
  task automatic wait_ready_a(input int exp_cycles, input bit inject);
    int cycles = 0;
    while (cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (inject && cycles == 9) begin
        req_a = 1'b1; faddr_a = 6'd12;
        ld_a = 1'b1; laddr_a = 6'd12; ldata_a = 64'hAAAA_5555_AAAA_5555;
      end
      if (inject && cycles == 10) begin
        check("init_load_err", {63'd0, err_a}, 64'd1);
        check("init_no_valid", {63'd0, valid_a}, 64'd0);
        idle_a();
      end
      if (inject && cycles == 11) begin
        check("init_err_once", {63'd0, err_a}, 64'd0);
        check("init_not_queued", {63'd0, valid_a}, 64'd0);
      end
      if (ready_a) break;
    end
    check("ready_latency_a", 64'(cycles), 64'(exp_cycles));
  endtask

  task automatic fetch_a(input logic [5:0] addr, input logic [63:0] exp, input string name);
    req_a = 1'b1; faddr_a = addr;
    @(negedge clk);
    idle_a();
    check({name, "_valid"}, {63'd0, valid_a}, 64'd1);
    check({name, "_data"}, data_a, exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    idle_a();
    req_b = 1'b0; faddr_b = '0; ld_b = 1'b0; laddr_b = '0; ldata_b = '0;

    // Back-to-back fetches, a load, read-before-write, then an independent fetch and load.
    vecs.push_back(mk(1, 6'd0,  0, 6'd0,  64'd0,                  1, 64'd0));
    vecs.push_back(mk(1, 6'd37, 0, 6'd0,  64'd0,                  1, 64'd37));
    vecs.push_back(mk(1, 6'd63, 0, 6'd0,  64'd0,                  1, 64'd63));
    vecs.push_back(mk(0, 6'd0,  1, 6'd5,  64'hDEAD_BEEF_0000_0001, 0, 64'd63));
    vecs.push_back(mk(1, 6'd5,  0, 6'd0,  64'd0,                  1, 64'hDEAD_BEEF_0000_0001));
    vecs.push_back(mk(1, 6'd6,  0, 6'd0,  64'd0,                  1, 64'd6));
    vecs.push_back(mk(1, 6'd9,  1, 6'd9,  64'hFF,                 1, 64'd9));
    vecs.push_back(mk(1, 6'd9,  0, 6'd0,  64'd0,                  1, 64'hFF));
    vecs.push_back(mk(0, 6'd0,  0, 6'd0,  64'd0,                  0, 64'hFF));
    vecs.push_back(mk(1, 6'd5,  1, 6'd20, 64'h1234,               1, 64'hDEAD_BEEF_0000_0001));
    vecs.push_back(mk(1, 6'd20, 0, 6'd0,  64'd0,                  1, 64'h1234));

    // Reset values and init latency.
    reset_a();
    wait_ready_a(64, 1'b0);

    // Apply the table with one vector per cycle and check its response on the next negedge.
    foreach (vecs[i]) begin
      req_a = vecs[i].req; faddr_a = vecs[i].faddr;
      ld_a = vecs[i].ld; laddr_a = vecs[i].laddr; ldata_a = vecs[i].ldata;
      exp_q.push_back(vecs[i].exp_data);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), {63'd0, valid_a}, {63'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_data", i), data_a, exp_q.pop_front());
      check($sformatf("vec%0d_err", i), {63'd0, err_a}, 64'd0);
    end
    idle_a();

    // Fetch and load during INIT are dropped, so address 12 keeps its pattern.
    reset_a();
    wait_ready_a(64, 1'b1);
    fetch_a(6'd12, 64'd12, "init_target");

    // Async reset in READY after a load to address 2.
    ld_a = 1'b1; laddr_a = 6'd2; ldata_a = 64'h5555;
    @(negedge clk);
    idle_a();
    fetch_a(6'd2, 64'h5555, "pre_reset_load");
    req_a = 1'b1; faddr_a = 6'd2;
    @(posedge clk);
    #2 rst_a = 1'b1;
    idle_a();
    #1;
    check("async_ready", {63'd0, ready_a}, 64'd0);
    check("async_valid", {63'd0, valid_a}, 64'd0);
    check("async_data", data_a, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    wait_ready_a(64, 1'b0);
    fetch_a(6'd2, 64'd2, "reinit_addr2");

    // Narrow instance: 16 words of 32 bits.
    begin
      int cycles = 0;
      @(negedge clk);
      rst_b = 1'b0;
      while (cycles < 100) begin
        @(negedge clk);
        cycles++;
        if (ready_b) break;
      end
      check("ready_latency_b", 64'(cycles), 64'd16);
      req_b = 1'b1; faddr_b = 4'd15;
      @(negedge clk);
      req_b = 1'b0;
      check("b_fetch15_valid", {63'd0, valid_b}, 64'd1);
      check("b_fetch15_data", {32'd0, data_b}, 64'd15);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
